user_mgr_arbiter: RTL and testbench

Round-robin arbiter that shares the single user-domain OBI manager port (toward the Croc interconnect/SRAM) between `NumReq` user-domain managers, e.g. the edge accelerator plus a future DMA or second accelerator. It sits in `user_domain` between the requesters and `user_mgr_obi_req_o`/`user_mgr_obi_rsp_i`. It grants at most one A-channel handshake per cycle and records the winner's index in an in-order tracking FIFO. Each R-channel beat is routed back to the oldest outstanding requester.

---
 rtl/user_mgr_arbiter_pkg.sv | 12 +
 rtl/user_mgr_arb_fifo.sv | 68 ++++++
 rtl/user_mgr_arbiter.sv | 152 +++++++++++++++
 tb/tb_user_mgr_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_mgr_arbiter_pkg.sv
// Shared constants and helpers for the user-domain manager arbiter.
// Imported by the arbiter top and its index FIFO.
package user_mgr_arbiter_pkg;

  localparam int unsigned NumUserMgrs     = 2;
  localparam int unsigned UserMgrMaxTrans = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_mgr_arb_fifo.sv
// In-order FIFO of requester indices for outstanding OBI transactions.
// Head is the issuer of the oldest transaction still awaiting rvalid.
module user_mgr_arb_fifo
  import user_mgr_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = idx_w(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q;
  logic [PtrW-1:0]  rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] nxt(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= nxt(wr_q);
      end
      if (do_pop) begin
        rd_q <= nxt(rd_q);
      end
      // simultaneous push and pop leaves the count unchanged
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NumReq managers.
// Responses are routed back in issue order via the index FIFO.
module user_mgr_arbiter
  import user_mgr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = NumUserMgrs,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = UserMgrMaxTrans
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*DataWidth/8-1:0] be_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*IdWidth-1:0]     aid_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic [IdWidth-1:0]            rid_o,
  output logic                          err_o,
  output logic                          mgr_req_o,
  output logic [AddrWidth-1:0]          mgr_addr_o,
  output logic                          mgr_we_o,
  output logic [DataWidth/8-1:0]        mgr_be_o,
  output logic [DataWidth-1:0]          mgr_wdata_o,
  output logic [IdWidth-1:0]            mgr_aid_o,
  input  logic                          mgr_gnt_i,
  input  logic                          mgr_rvalid_i,
  input  logic [DataWidth-1:0]          mgr_rdata_i,
  input  logic [IdWidth-1:0]            mgr_rid_i,
  input  logic                          mgr_err_i,
  output logic                          spurious_o
);

  localparam int unsigned IdxW = idx_w(NumReq);
  localparam int unsigned BeW  = DataWidth / 8;

  logic [IdxW-1:0]      rr_ptr;
  logic [IdxW-1:0]      lock_idx_q;
  logic                 lock_q;
  logic                 spurious_q;
  logic [IdxW-1:0]      sel;
  logic                 found;
  logic [IdxW-1:0]      head;
  logic                 full;
  logic                 empty;
  logic                 hs;
  logic                 pop;
  logic [AddrWidth-1:0] a_addr;
  logic                 a_we;
  logic [BeW-1:0]       a_be;
  logic [DataWidth-1:0] a_wdata;
  logic [IdWidth-1:0]   a_aid;

  // two passes: indices at or above rr_ptr first, then wrap to 0
  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (lock_q) begin
      sel   = lock_idx_q;
      found = 1'b1;
    end else begin
      for (int j = 0; j < NumReq; j++) begin
        if (!found && req_i[j] && IdxW'(j) >= rr_ptr) begin
          sel   = IdxW'(j);
          found = 1'b1;
        end
      end
      for (int j = 0; j < NumReq; j++) begin
        if (!found && req_i[j]) begin
          sel   = IdxW'(j);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_addr  = '0;
    a_we    = 1'b0;
    a_be    = '0;
    a_wdata = '0;
    a_aid   = '0;
    for (int j = 0; j < NumReq; j++) begin
      if (sel == IdxW'(j)) begin
        a_addr  = addr_i[j*AddrWidth +: AddrWidth];
        a_we    = we_i[j];
        a_be    = be_i[j*BeW +: BeW];
        a_wdata = wdata_i[j*DataWidth +: DataWidth];
        a_aid   = aid_i[j*IdWidth +: IdWidth];
      end
    end
  end

  assign mgr_req_o = !rst_i && (|req_i) && !full;
  assign hs        = mgr_req_o && mgr_gnt_i;
  assign pop       = !rst_i && mgr_rvalid_i && !empty;

  assign mgr_addr_o  = mgr_req_o ? a_addr  : '0;
  assign mgr_we_o    = mgr_req_o ? a_we    : 1'b0;
  assign mgr_be_o    = mgr_req_o ? a_be    : '0;
  assign mgr_wdata_o = mgr_req_o ? a_wdata : '0;
  assign mgr_aid_o   = mgr_req_o ? a_aid   : '0;

  assign gnt_o    = hs  ? (NumReq'(1) << sel)  : '0;
  assign rvalid_o = pop ? (NumReq'(1) << head) : '0;

  assign rdata_o    = rst_i ? '0   : mgr_rdata_i;
  assign rid_o      = rst_i ? '0   : mgr_rid_i;
  assign err_o      = rst_i ? 1'b0 : mgr_err_i;
  assign spurious_o = spurious_q;

  // lock holds the pending selection stable until it is granted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
        lock_q <= 1'b0;
      end else if (mgr_req_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (mgr_rvalid_i && empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

  user_mgr_arb_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// Self-checking bench for user_mgr_arbiter with a queue-based reference
// model of round-robin selection, locking and in-order response routing.
module tb_user_mgr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int MT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   addr;
  logic [N-1:0]      we;
  logic [N*DW/8-1:0] be;
  logic [N*DW-1:0]   wdata;
  logic [N*IW-1:0]   aid;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic [IW-1:0]     rid_o;
  logic              err_o;
  logic              mgr_req_o;
  logic [AW-1:0]     mgr_addr_o;
  logic              mgr_we_o;
  logic [DW/8-1:0]   mgr_be_o;
  logic [DW-1:0]     mgr_wdata_o;
  logic [IW-1:0]     mgr_aid_o;
  logic              mgr_gnt;
  logic              mgr_rvalid;
  logic [DW-1:0]     mgr_rdata;
  logic [IW-1:0]     mgr_rid;
  logic              mgr_err;
  logic              spurious_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_rr;
  int m_lock;
  int m_q[$];
  bit m_spur;

  // expectations for the current cycle
  int           e_sel;
  bit           e_mreq;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_rv;

  always #5 clk = ~clk;

  user_mgr_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW),
    .IdWidth(IW), .MaxTrans(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .aid_i(aid),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rid_o(rid_o), .err_o(err_o),
    .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o),
    .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o),
    .mgr_wdata_o(mgr_wdata_o), .mgr_aid_o(mgr_aid_o),
    .mgr_gnt_i(mgr_gnt), .mgr_rvalid_i(mgr_rvalid),
    .mgr_rdata_i(mgr_rdata), .mgr_rid_i(mgr_rid),
    .mgr_err_i(mgr_err), .spurious_o(spurious_o)
  );

  function automatic void model_reset();
    m_rr   = 0;
    m_lock = -1;
    m_q.delete();
    m_spur = 0;
  endfunction

  function automatic void model_eval();
    bit f;
    f     = 0;
    e_sel = 0;
    if (m_lock >= 0) begin
      e_sel = m_lock;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (!f && req[k]) begin
          e_sel = k;
          f     = 1;
        end
      end
    end
    e_mreq = (req != 0) && (m_q.size() < MT);
    e_gnt  = (e_mreq && mgr_gnt) ? (N'(1) << e_sel) : '0;
    e_rv   = (mgr_rvalid && m_q.size() > 0) ? (N'(1) << m_q[0]) : '0;
  endfunction

  function automatic void model_commit();
    if (mgr_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_spur = 1;
    end
    if (e_mreq && mgr_gnt) begin
      m_q.push_back(e_sel);
      m_rr   = (e_sel + 1) % N;
      m_lock = -1;
    end else if (e_mreq) begin
      m_lock = e_sel;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; addr = '0; we = '0; be = '0; wdata = '0; aid = '0;
    mgr_gnt = 0; mgr_rvalid = 0; mgr_rdata = '0;
    mgr_rid = '0; mgr_err = 0;
  endtask

  task automatic drain();
    req = '0; mgr_gnt = 0; mgr_rvalid = 1;
    for (int c = 0; c < MT + 1 && m_q.size() > 0; c++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (rvalid_o !== e_rv) begin
        errors++;
        $display("FAIL drain_rvalid got %b exp %b", rvalid_o, e_rv);
      end
      tick();
    end
    checks++;
    if (m_q.size() != 0) begin
      errors++;
      $display("FAIL drain_bound got %0d left exp 0", m_q.size());
    end
    mgr_rvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({mgr_req_o, gnt_o, rvalid_o, spurious_o} !== '0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 0",
               {mgr_req_o, gnt_o, rvalid_o, spurious_o});
    end
    tick();
    req = 2'b01; addr[AW-1:0] = 32'hDEAD_0000;
    mgr_gnt = 1; mgr_rdata = 32'h1234_5678;
    #2;
    checks++;
    if (mgr_req_o !== 1'b1 || gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_req got %b/%b exp 1/01",
               mgr_req_o, gnt_o);
    end
    rst = 1;
    #1;
    checks++;
    if ({mgr_req_o, gnt_o, rvalid_o, spurious_o} !== '0 ||
        mgr_addr_o !== '0 || rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_async got %b addr %h rdata %h exp 0",
               {mgr_req_o, gnt_o, rvalid_o, spurious_o},
               mgr_addr_o, rdata_o);
    end
    @(posedge clk);
    #1 rst = 0;
    idle_inputs();
    model_reset();
  endtask

  task automatic test_single();
    req = 2'b01; addr[AW-1:0] = 32'h1000_0000; mgr_gnt = 1;
    @(negedge clk);
    model_eval();
    checks++;
    if (mgr_addr_o !== 32'h1000_0000 || gnt_o !== 2'b01 ||
        gnt_o !== e_gnt) begin
      errors++;
      $display("FAIL single_grant got %h/%b exp 10000000/01",
               mgr_addr_o, gnt_o);
    end
    tick();
    req = '0; mgr_gnt = 0;
    mgr_rvalid = 1; mgr_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    model_eval();
    checks++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hCAFE_F00D ||
        rvalid_o !== e_rv) begin
      errors++;
      $display("FAIL single_resp got %b/%h exp 01/cafef00d",
               rvalid_o, rdata_o);
    end
    tick();
    mgr_rvalid = 0;
  endtask

  task automatic test_contention();
    logic [N-1:0] prev;
    prev = '0;
    addr = {32'hB000_0004, 32'hA000_0000};
    req = 2'b11; mgr_gnt = 1;
    for (int c = 0; c < 8; c++) begin
      mgr_rvalid = (c > 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (gnt_o !== e_gnt || (c > 0 && gnt_o !== ~prev)) begin
        errors++;
        $display("FAIL contend_gnt c%0d got %b exp %b", c, gnt_o, e_gnt);
      end
      checks++;
      if (mgr_addr_o !== addr[e_sel*AW +: AW]) begin
        errors++;
        $display("FAIL contend_addr got %h exp %h",
                 mgr_addr_o, addr[e_sel*AW +: AW]);
      end
      checks++;
      if (rvalid_o !== e_rv || (c > 0 && rvalid_o !== prev)) begin
        errors++;
        $display("FAIL contend_rvalid got %b exp %b", rvalid_o, prev);
      end
      prev = gnt_o;
      tick();
    end
    drain();
  endtask

  task automatic test_lock();
    addr = {32'h2222_0000, 32'h1111_0000};
    mgr_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      req = (c == 0) ? 2'b10 : 2'b11;
      @(negedge clk);
      model_eval();
      checks++;
      if (mgr_addr_o !== 32'h2222_0000 || gnt_o !== 2'b00 ||
          mgr_req_o !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold c%0d got %h/%b exp 22220000/00",
                 c, mgr_addr_o, gnt_o);
      end
      tick();
    end
    mgr_gnt = 1;
    @(negedge clk);
    model_eval();
    checks++;
    if (gnt_o !== 2'b10 || gnt_o !== e_gnt) begin
      errors++;
      $display("FAIL lock_first got %b exp 10", gnt_o);
    end
    tick();
    req = 2'b01;
    @(negedge clk);
    model_eval();
    checks++;
    if (gnt_o !== 2'b01 || mgr_addr_o !== 32'h1111_0000) begin
      errors++;
      $display("FAIL lock_next got %b/%h exp 01/11110000",
               gnt_o, mgr_addr_o);
    end
    tick();
    drain();
  endtask

  task automatic test_full();
    logic [4:0] ereq [6];
    logic [N-1:0] egnt [6];
    logic [N-1:0] erv [6];
    ereq = '{1, 1, 0, 0, 1, 0};
    egnt = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    erv  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 6; c++) begin
      req        = (c == 0) ? 2'b01 : (c == 5) ? 2'b00 : 2'b11;
      mgr_gnt    = (c != 5);
      mgr_rvalid = (c >= 3);
      @(negedge clk);
      model_eval();
      checks++;
      if (mgr_req_o !== ereq[c][0] || gnt_o !== egnt[c] ||
          rvalid_o !== erv[c] || gnt_o !== e_gnt ||
          rvalid_o !== e_rv) begin
        errors++;
        $display("FAIL full c%0d got %b/%b/%b exp %b/%b/%b", c,
                 mgr_req_o, gnt_o, rvalid_o, ereq[c][0], egnt[c], erv[c]);
      end
      tick();
    end
    mgr_rvalid = 0;
    mgr_gnt = 0;
  endtask

  task automatic test_spurious();
    mgr_rvalid = 1;
    @(negedge clk);
    model_eval();
    checks++;
    if (rvalid_o !== 2'b00 || spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_drop got %b/%b exp 00/0", rvalid_o, spurious_o);
    end
    tick();
    mgr_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (spurious_o !== 1'b1 || spurious_o !== m_spur) begin
        errors++;
        $display("FAIL spur_sticky got %b exp 1", spurious_o);
      end
      tick();
    end
    req = 2'b10; mgr_gnt = 1;
    @(negedge clk);
    model_eval();
    tick();
    req = '0; mgr_gnt = 0;
    rst = 1;
    #1;
    checks++;
    if (spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear got %b exp 0", spurious_o);
    end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    mgr_rvalid = 1;
    @(negedge clk);
    model_eval();
    checks++;
    if (rvalid_o !== 2'b00 || rvalid_o !== e_rv) begin
      errors++;
      $display("FAIL reset_discard got %b exp 00", rvalid_o);
    end
    tick();
    mgr_rvalid = 0;
    @(negedge clk);
    checks++;
    if (spurious_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_spur got %b exp 1", spurious_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] last_gnt;
    logic [AW+1+DW/8+DW+IW-1:0] e_a;
    last_gnt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] || last_gnt[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          addr[k*AW +: AW]   = $urandom;
          we[k]              = 1'($urandom_range(0, 1));
          be[k*4 +: 4]       = 4'($urandom);
          wdata[k*DW +: DW]  = $urandom;
          aid[k*IW +: IW]    = IW'($urandom);
        end
      end
      mgr_gnt    = ($urandom_range(0, 3) != 0);
      mgr_rvalid = (m_q.size() > 0) ? 1'($urandom_range(0, 1))
                                    : ($urandom_range(0, 39) == 0);
      mgr_rdata  = $urandom;
      mgr_rid    = IW'($urandom);
      mgr_err    = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_eval();
      e_a = e_mreq ? {addr[e_sel*AW +: AW], we[e_sel],
                      be[e_sel*4 +: 4], wdata[e_sel*DW +: DW],
                      aid[e_sel*IW +: IW]} : '0;
      checks++;
      if (mgr_req_o !== e_mreq || gnt_o !== e_gnt) begin
        errors++;
        $display("FAIL rand_req c%0d got %b/%b exp %b/%b",
                 c, mgr_req_o, gnt_o, e_mreq, e_gnt);
      end
      checks++;
      if ({mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o, mgr_aid_o}
          !== e_a) begin
        errors++;
        $display("FAIL rand_afields c%0d got %h exp %h", c,
                 {mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o, mgr_aid_o},
                 e_a);
      end
      checks++;
      if (rvalid_o !== e_rv || rdata_o !== mgr_rdata ||
          rid_o !== mgr_rid || err_o !== mgr_err) begin
        errors++;
        $display("FAIL rand_resp c%0d got %b/%h exp %b/%h",
                 c, rvalid_o, rdata_o, e_rv, mgr_rdata);
      end
      checks++;
      if (spurious_o !== m_spur) begin
        errors++;
        $display("FAIL rand_spur c%0d got %b exp %b", c, spurious_o, m_spur);
      end
      last_gnt = e_gnt;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_full();
    test_spurious();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    idle_inputs();
    model_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
